mem_arbiter: RTL and testbench

- Shares the core's single-port, synchronous-read unified memory between the instruction-fetch requester and the load/store requester.
- The load/store requester is driven by the decoder's memWr/memToReg/maskSel signals.
- Grants one access per cycle, steers the returned read data back to its owner one cycle later, and bounds fetch starvation.
- Sits between the core (fetch unit, load/store unit) and the RAM.

---
 rtl/arb_pkg.sv | 15 +
 rtl/starve_counter.sv | 29 ++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the memory arbiter: who owns the access currently in
// flight, and the default fetch-starvation bound.
package arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_IF   = 2'b01,
      OWN_DR   = 2'b10,
      OWN_DW   = 2'b11
   } owner_t;

   localparam int STARVE_LIMIT_DEFAULT = 4;
   localparam int STARVE_CNT_W         = 4;

endpackage

// File: rtl/starve_counter.sv
// Saturating counter of consecutive data grants taken while a fetch waits;
// full tells the arbiter that fetch must win the next contested cycle.
module starve_counter #(
   parameter int LIMIT = 4,
   parameter int CNT_W = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic full
);

   logic [CNT_W-1:0] count;

   // Clear has priority so a fetch grant always restarts the window.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !full) begin
         count <= count + CNT_W'(1);
      end
   end

   assign full = (count == CNT_W'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store: one
// grant per cycle, read data steered back one cycle later, bounded fetch starvation.
module mem_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic                clk,
   input  logic                rstN,
   input  logic                ifReq,
   input  logic [ADDR_W-1:0]   ifAddr,
   output logic                ifGnt,
   output logic                ifValid,
   output logic [DATA_W-1:0]   ifRdata,
   input  logic                dReq,
   input  logic                dWe,
   input  logic [ADDR_W-1:0]   dAddr,
   input  logic [DATA_W-1:0]   dWdata,
   input  logic [DATA_W/8-1:0] dMask,
   output logic                dGnt,
   output logic                dValid,
   output logic [DATA_W-1:0]   dRdata,
   output logic                memEn,
   output logic                memWe,
   output logic [ADDR_W-1:0]   memAddr,
   output logic [DATA_W-1:0]   memWdata,
   output logic [DATA_W/8-1:0] memMask,
   input  logic [DATA_W-1:0]   memRdata
);

   localparam int MASK_W = DATA_W / 8;

   generate
      if (DATA_W % 8 != 0) begin : g_bad_data_w
         $error("mem_arbiter: DATA_W must be a multiple of 8");
      end
      if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
         $error("mem_arbiter: STARVE_LIMIT must be in 1..15");
      end
   endgenerate

   owner_t owner;
   owner_t owner_next;
   logic   if_gnt;
   logic   d_gnt;
   logic   starve_full;
   logic   starve_clr;
   logic   starve_inc;

   always_ff @(posedge clk) begin
      if (!rstN) begin
         owner <= OWN_NONE;
      end else begin
         owner <= owner_next;
      end
   end

   // Data wins by default; fetch wins a contested cycle once the data side
   // has taken STARVE_LIMIT grants in a row while fetch was waiting.
   always_comb begin
      if_gnt     = 1'b0;
      d_gnt      = 1'b0;
      owner_next = OWN_NONE;
      memEn      = 1'b0;
      memWe      = 1'b0;
      memAddr    = '0;
      memWdata   = '0;
      memMask    = '0;
      if (rstN) begin
         if (dReq && !(ifReq && starve_full)) begin
            d_gnt = 1'b1;
         end else if (ifReq) begin
            if_gnt = 1'b1;
         end
         if (if_gnt) begin
            owner_next = OWN_IF;
            memEn      = 1'b1;
            memAddr    = ifAddr;
            memMask    = {MASK_W{1'b1}};
         end else if (d_gnt) begin
            owner_next = dWe ? OWN_DW : OWN_DR;
            memEn      = 1'b1;
            memWe      = dWe;
            memAddr    = dAddr;
            memWdata   = dWdata;
            memMask    = dMask;
         end
      end
   end

   assign ifGnt      = if_gnt;
   assign dGnt       = d_gnt;
   assign starve_clr = if_gnt | ~ifReq;
   assign starve_inc = ifReq & d_gnt;

   starve_counter #(
      .LIMIT (STARVE_LIMIT),
      .CNT_W (STARVE_CNT_W)
   ) u_starve (
      .clk   (clk),
      .rst_n (rstN),
      .clr   (starve_clr),
      .inc   (starve_inc),
      .full  (starve_full)
   );

   // The owner register is still set during the reset cycle, so the return
   // path is gated by rstN to drop any result that was in flight.
   always_comb begin
      ifValid = 1'b0;
      ifRdata = '0;
      dValid  = 1'b0;
      dRdata  = '0;
      if (rstN) begin
         unique case (owner)
            OWN_IF: begin
               ifValid = 1'b1;
               ifRdata = memRdata;
            end
            OWN_DR: begin
               dValid = 1'b1;
               dRdata = memRdata;
            end
            OWN_DW: begin
               dValid = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural model predicts grants, RAM
// drive and returned data; a monitor checks each valid against the queue.
module tb_mem_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rstN;
   logic        ifReq;
   logic [31:0] ifAddr;
   logic        ifGnt;
   logic        ifValid;
   logic [31:0] ifRdata;
   logic        dReq;
   logic        dWe;
   logic [31:0] dAddr;
   logic [31:0] dWdata;
   logic [3:0]  dMask;
   logic        dGnt;
   logic        dValid;
   logic [31:0] dRdata;
   logic        memEn;
   logic        memWe;
   logic [31:0] memAddr;
   logic [31:0] memWdata;
   logic [3:0]  memMask;
   logic [31:0] memRdata;

   always #5 clk = ~clk;

   mem_arbiter #(
      .ADDR_W       (32),
      .DATA_W       (32),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk      (clk),
      .rstN     (rstN),
      .ifReq    (ifReq),
      .ifAddr   (ifAddr),
      .ifGnt    (ifGnt),
      .ifValid  (ifValid),
      .ifRdata  (ifRdata),
      .dReq     (dReq),
      .dWe      (dWe),
      .dAddr    (dAddr),
      .dWdata   (dWdata),
      .dMask    (dMask),
      .dGnt     (dGnt),
      .dValid   (dValid),
      .dRdata   (dRdata),
      .memEn    (memEn),
      .memWe    (memWe),
      .memAddr  (memAddr),
      .memWdata (memWdata),
      .memMask  (memMask),
      .memRdata (memRdata)
   );

   // Environment RAM: synchronous read, byte-masked write.
   logic        ram_clear;
   logic [31:0] ram [0:255];
   logic [31:0] ram_rd;

   assign memRdata = ram_rd;

   always @(posedge clk) begin
      if (ram_clear) begin
         for (int i = 0; i < 256; i++) ram[i] <= (i == 64) ? 32'h0050_0093 : 32'h0;
         ram_rd <= '0;
      end else if (memEn) begin
         if (memWe) begin
            for (int b = 0; b < 4; b++)
               if (memMask[b]) ram[8'(memAddr >> 2)][b*8 +: 8] <= memWdata[b*8 +: 8];
         end else begin
            ram_rd <= ram[8'(memAddr >> 2)];
         end
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          tag;
      logic [31:0] data;
   } exp_t;

   exp_t        if_q[$];
   exp_t        d_q[$];
   int          total = 0;
   int          bad = 0;
   int          starve;
   logic [31:0] mmem [0:255];
   logic        last_if_gnt;
   logic        last_d_gnt;
   logic        dut_if_gnt;

   function automatic int widx(input logic [31:0] a);
      return int'(8'(a >> 2));
   endfunction

   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Predict this cycle's grants and RAM drive from the arbitration rules,
   // queue the expected return, then advance the model's state.
   task automatic check_output();
      logic e_if;
      logic e_d;
      int   k;
      dut_if_gnt = ifGnt;
      if (!rstN) begin
         compare("rst_ifGnt", 32'(ifGnt), 32'd0);
         compare("rst_dGnt", 32'(dGnt), 32'd0);
         compare("rst_memEn", 32'(memEn), 32'd0);
         compare("rst_memWe", 32'(memWe), 32'd0);
         compare("rst_memAddr", memAddr, 32'd0);
         compare("rst_memWdata", memWdata, 32'd0);
         compare("rst_memMask", 32'(memMask), 32'd0);
         starve = 0;
         last_if_gnt = 1'b0;
         last_d_gnt = 1'b0;
         return;
      end
      e_d  = dReq && (!ifReq || starve < LIMIT);
      e_if = ifReq && !e_d;
      compare("ifGnt", 32'(ifGnt), 32'(e_if));
      compare("dGnt", 32'(dGnt), 32'(e_d));
      compare("memEn", 32'(memEn), 32'(e_if | e_d));
      if (e_if) begin
         compare("memWe_if", 32'(memWe), 32'd0);
         compare("memAddr_if", memAddr, ifAddr);
         compare("memMask_if", 32'(memMask), 32'hF);
         if_q.push_back('{cyc, mmem[widx(ifAddr)]});
      end else if (e_d) begin
         compare("memWe_d", 32'(memWe), 32'(dWe));
         compare("memAddr_d", memAddr, dAddr);
         compare("memWdata_d", memWdata, dWdata);
         compare("memMask_d", 32'(memMask), 32'(dMask));
         k = widx(dAddr);
         if (dWe) begin
            for (int b = 0; b < 4; b++)
               if (dMask[b]) mmem[k][b*8 +: 8] = dWdata[b*8 +: 8];
            d_q.push_back('{cyc, 32'h0});
         end else begin
            d_q.push_back('{cyc, mmem[k]});
         end
      end else begin
         compare("memAddr_idle", memAddr, 32'd0);
         compare("memWdata_idle", memWdata, 32'd0);
         compare("memMask_idle", 32'(memMask), 32'd0);
      end
      if (ifReq && e_d) starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
      else starve = 0;
      last_if_gnt = e_if;
      last_d_gnt = e_d;
   endtask

   task automatic step();
      @(negedge clk);
      check_output();
      @(posedge clk);
      #1;
   endtask

   task automatic enter_reset();
      rstN = 1'b0;
      if_q.delete();
      d_q.delete();
   endtask

   task automatic new_d(input logic we);
      dReq   = 1'b1;
      dWe    = we;
      dAddr  = {22'd0, 8'($urandom), 2'b00};
      dWdata = $urandom;
      dMask  = 4'($urandom);
   endtask

   // Random requesters: keep a pending request stable until granted, with an
   // occasional withdrawal; otherwise maybe start a new one.
   task automatic apply_stimulus();
      if (ifReq && !last_if_gnt) begin
         if ($urandom_range(0, 15) == 0) ifReq = 1'b0;
      end else begin
         ifReq  = ($urandom_range(0, 1) == 1);
         ifAddr = {22'd0, 8'($urandom), 2'b00};
      end
      if (dReq && !last_d_gnt) begin
         if ($urandom_range(0, 15) == 0) dReq = 1'b0;
      end else if ($urandom_range(0, 2) != 0) begin
         new_d(1'($urandom));
      end else begin
         dReq = 1'b0;
      end
   endtask

   // Monitor: a valid is expected exactly when a grant was predicted last cycle.
   initial begin
      exp_t        e;
      logic        v;
      logic [31:0] dat;
      forever begin
         @(negedge clk);
         v = 1'b0;
         dat = '0;
         if (if_q.size() > 0 && if_q[0].tag == cyc - 1) begin
            e = if_q.pop_front();
            v = 1'b1;
            dat = e.data;
         end
         compare("ifValid", 32'(ifValid), 32'(v));
         compare("ifRdata", ifRdata, dat);
         v = 1'b0;
         dat = '0;
         if (d_q.size() > 0 && d_q[0].tag == cyc - 1) begin
            e = d_q.pop_front();
            v = 1'b1;
            dat = e.data;
         end
         compare("dValid", 32'(dValid), 32'(v));
         compare("dRdata", dRdata, dat);
      end
   end

   initial begin
      logic [9:0] seq;
      rstN = 1'b0;
      ram_clear = 1'b1;
      starve = 0;
      last_if_gnt = 1'b0;
      last_d_gnt = 1'b0;
      for (int i = 0; i < 256; i++) mmem[i] = (i == 64) ? 32'h0050_0093 : 32'h0;
      ifReq = 1'b1;
      ifAddr = 32'h100;
      dReq = 1'b1;
      dWe = 1'b0;
      dAddr = 32'h300;
      dWdata = '0;
      dMask = '0;
      #1;
      for (int i = 0; i < 3; i++) step();
      ram_clear = 1'b0;
      rstN = 1'b1;
      step();
      dReq = 1'b0;
      step();
      ifReq = 1'b0;
      step();

      new_d(1'b1);
      dAddr = 32'h200;
      dWdata = 32'hAABB_CCDD;
      dMask = 4'b0011;
      step();
      dWe = 1'b0;
      step();
      dReq = 1'b0;
      step();

      ifReq = 1'b1;
      ifAddr = 32'h104;
      new_d(1'b0);
      seq = '0;
      for (int i = 0; i < 10; i++) begin
         step();
         seq[i] = dut_if_gnt;
         if (last_d_gnt) new_d(1'b0);
      end
      compare("starve_pattern", 32'(seq), 32'(10'b10_0001_0000));
      ifReq = 1'b0;
      dReq = 1'b0;
      step();

      new_d(1'b0);
      step();
      dReq = 1'b0;
      enter_reset();
      step();
      step();
      rstN = 1'b1;
      step();
      step();

      new_d(1'b1);
      ifReq = 1'b1;
      step();
      ifReq = 1'b0;
      new_d(1'b1);
      step();
      new_d(1'b0);
      step();
      dReq = 1'b0;
      step();

      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            enter_reset();
            step();
            if ($urandom_range(0, 1) == 1) step();
            rstN = 1'b1;
         end
         apply_stimulus();
         step();
      end

      ifReq = 1'b0;
      dReq = 1'b0;
      for (int i = 0; i < 3; i++) step();
      compare("if_q_drained", 32'(if_q.size()), 32'd0);
      compare("d_q_drained", 32'(d_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
